// File: rtl/crc32_pkg.sv
// Shared constants, state type and helpers for the Avalon CRC-32 responder.
// The engine bit order is selected by CRC_REFLECT_EN.
package crc32_pkg;

  localparam logic [31:0] DEF_CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_CRC_INIT = 32'hFFFFFFFF;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_CRC    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_OVERRUN = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_bit_engine.sv
// Bit-serial CRC-32 engine: folds one 32-bit word into the CRC, one bit per clock.
// CRC_REFLECT_EN selects LSB-first (reflected) shifting; default is MSB-first.
module crc32_bit_engine
  import crc32_pkg::*;
#(
  parameter logic [31:0] CRC_POLY = DEF_CRC_POLY,
  parameter logic [31:0] CRC_INIT = DEF_CRC_INIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] data,
  input  logic        seed_load,
  input  logic [3:0]  seed_be,
  input  logic [31:0] seed,
  input  logic        init,
  input  logic        abort,
  output logic [31:0] crc,
  output logic        busy,
  output logic        done_pulse
);

  state_t      r_state;
  logic [31:0] r_sr;
  logic [31:0] r_crc;
  logic [4:0]  r_cnt;

  logic        w_fb;
  logic [31:0] w_crc_next;
  logic [31:0] w_sr_next;
  logic [31:0] w_seed_merged;

  always_comb begin
`ifdef CRC_REFLECT_EN
    w_fb       = r_crc[0] ^ r_sr[0];
    w_crc_next = (r_crc >> 1) ^ (w_fb ? bitrev32(CRC_POLY) : 32'h0);
    w_sr_next  = r_sr >> 1;
`else
    w_fb       = r_crc[31] ^ r_sr[31];
    w_crc_next = {r_crc[30:0], 1'b0} ^ (w_fb ? CRC_POLY : 32'h0);
    w_sr_next  = {r_sr[30:0], 1'b0};
`endif
  end

  always_comb begin
    w_seed_merged = r_crc;
    for (int b = 0; b < 4; b++)
      if (seed_be[b]) w_seed_merged[8*b +: 8] = seed[8*b +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sr    <= 32'h0;
      r_crc   <= CRC_INIT;
      r_cnt   <= 5'd0;
    end else begin
      // Seed writes only land between words; a mid-word seed would corrupt the result.
      if (init)                           r_crc <= CRC_INIT;
      else if (r_state == IDLE && seed_load) r_crc <= w_seed_merged;
      else if (r_state == SHIFT)          r_crc <= w_crc_next;

      if (abort) begin
        r_state <= IDLE;
      end else if (r_state == IDLE) begin
        if (load) begin
          r_sr    <= data;
          r_cnt   <= 5'd0;
          r_state <= SHIFT;
        end
      end else begin
        r_sr  <= w_sr_next;
        r_cnt <= r_cnt + 5'd1;
        if (r_cnt == 5'd31) r_state <= IDLE;
      end
    end
  end

  assign crc        = r_crc;
  assign busy       = (r_state == SHIFT);
  assign done_pulse = (r_state == SHIFT) && (r_cnt == 5'd31) && !abort;

endmodule

// File: rtl/avalon_crc32_slave.sv
// Avalon-MM CRC-32 responder: register decode, status flags and 1-cycle registered reads.
// Build option CRC_REFLECT_EN switches the engine to LSB-first shifting.
module avalon_crc32_slave
  import crc32_pkg::*;
#(
  parameter logic [31:0] CRC_POLY = DEF_CRC_POLY,
  parameter logic [31:0] CRC_INIT = DEF_CRC_INIT
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        AVL_CS,
  input  logic        AVL_READ,
  input  logic        AVL_WRITE,
  input  logic [1:0]  AVL_ADDR,
  input  logic [3:0]  AVL_BYTE_EN,
  input  logic [31:0] AVL_WRITEDATA,
  output logic [31:0] AVL_READDATA,
  output logic        BUSY
);

  logic        w_wr, w_rd;
  logic        w_init, w_data_wr, w_seed_wr, w_ovr_clr;
  logic [31:0] w_crc;
  logic        w_busy, w_done_pulse;
  logic [31:0] w_status;

  logic        r_done;
  logic        r_overrun;
  logic [31:0] r_readdata;

  assign w_wr      = AVL_CS & AVL_WRITE;
  assign w_rd      = AVL_CS & AVL_READ;
  assign w_init    = w_wr && (AVL_ADDR == ADDR_CTRL) && AVL_WRITEDATA[0];
  assign w_data_wr = w_wr && (AVL_ADDR == ADDR_DATA);
  assign w_seed_wr = w_wr && (AVL_ADDR == ADDR_CRC);
  assign w_ovr_clr = w_wr && (AVL_ADDR == ADDR_STATUS) && AVL_WRITEDATA[STAT_OVERRUN];

  crc32_bit_engine #(
    .CRC_POLY (CRC_POLY),
    .CRC_INIT (CRC_INIT)
  ) u_engine (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .load       (w_data_wr),
    .data       (AVL_WRITEDATA),
    .seed_load  (w_seed_wr),
    .seed_be    (AVL_BYTE_EN),
    .seed       (AVL_WRITEDATA),
    .init       (w_init),
    .abort      (w_init),
    .crc        (w_crc),
    .busy       (w_busy),
    .done_pulse (w_done_pulse)
  );

  always_comb begin
    w_status                = 32'h0;
    w_status[STAT_BUSY]     = w_busy;
    w_status[STAT_DONE]     = r_done;
    w_status[STAT_OVERRUN]  = r_overrun;
  end

  // A DATA write while busy (including the final-bit cycle) is dropped and flagged.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
      r_readdata <= 32'h0;
    end else begin
      if (w_init)                    r_done <= 1'b0;
      else if (w_done_pulse)         r_done <= 1'b1;
      else if (w_data_wr && !w_busy) r_done <= 1'b0;

      if (w_data_wr && w_busy) r_overrun <= 1'b1;
      else if (w_ovr_clr)      r_overrun <= 1'b0;

      if (w_rd) begin
        case (AVL_ADDR)
          ADDR_CRC:    r_readdata <= w_crc;
          ADDR_STATUS: r_readdata <= w_status;
          default:     r_readdata <= 32'h0;
        endcase
      end
    end
  end

  assign AVL_READDATA = r_readdata;
  assign BUSY         = w_busy;

endmodule

// File: tb/tb_avalon_crc32_slave.sv
// Scoreboard bench for avalon_crc32_slave: reads push expected data, a monitor checks returned data.
module tb_avalon_crc32_slave;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        AVL_CS = 1'b0;
  logic        AVL_READ = 1'b0;
  logic        AVL_WRITE = 1'b0;
  logic [1:0]  AVL_ADDR = 2'd0;
  logic [3:0]  AVL_BYTE_EN = 4'h0;
  logic [31:0] AVL_WRITEDATA = 32'h0;
  logic [31:0] AVL_READDATA;
  logic        BUSY;

  localparam logic [1:0] A_CTRL = 2'd0, A_DATA = 2'd1, A_CRC = 2'd2, A_STAT = 2'd3;

`ifdef CRC_REFLECT_EN
  localparam logic [31:0] D1 = 32'h80000000;
  localparam logic [31:0] E1 = 32'hEDB88320;
`else
  localparam logic [31:0] D1 = 32'h00000001;
  localparam logic [31:0] E1 = 32'h04C11DB7;
`endif

  always #10 CLK = ~CLK;

  avalon_crc32_slave dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .AVL_CS        (AVL_CS),
    .AVL_READ      (AVL_READ),
    .AVL_WRITE     (AVL_WRITE),
    .AVL_ADDR      (AVL_ADDR),
    .AVL_BYTE_EN   (AVL_BYTE_EN),
    .AVL_WRITEDATA (AVL_WRITEDATA),
    .AVL_READDATA  (AVL_READDATA),
    .BUSY          (BUSY)
  );

  int          n_total = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_d;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) rd_d <= 1'b0;
    else          rd_d <= AVL_CS && AVL_READ;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    string       nm;
    logic [31:0] e;
    forever begin
      @(negedge CLK);
      if (rd_d) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_read: got %h expected no read", AVL_READDATA);
        end else begin
          nm = name_q.pop_front();
          e  = exp_q.pop_front();
          check(nm, AVL_READDATA, e);
        end
      end
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    @(posedge CLK); #1;
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    @(posedge CLK); #1;
    AVL_CS = 1'b0; AVL_READ = 1'b0;
  endtask

  task automatic cycles(input int k);
    repeat (k) @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (BUSY && n < 100) begin
      n++;
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    fork
      monitor();
    join_none

    repeat (3) @(posedge CLK);
    #1;
    check("reset_readdata", AVL_READDATA, 32'h0);
    check("reset_busy", {31'b0, BUSY}, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    rd(A_CRC,  32'hFFFFFFFF, "reset_crc");
    rd(A_STAT, 32'h0,        "reset_status");

    wr(A_CRC, 32'h12345678, 4'b0011);
    rd(A_CRC, 32'hFFFF5678, "seed_byte_en");

    // single word from zero seed
    wr(A_CRC, 32'h0, 4'hF);
    wr(A_DATA, D1, 4'hF);
    wait_idle(n);
    check("busy_cycles", 32'(n), 32'd32);
    rd(A_STAT, 32'h2, "status_done");
    rd(A_CRC,  E1,    "crc_single");
    rd(A_CTRL, 32'h0, "ctrl_read");

    // INIT then all-ones word cancels to zero
    wr(A_CTRL, 32'h1, 4'hF);
    rd(A_CRC,  32'hFFFFFFFF, "init_crc");
    rd(A_STAT, 32'h0,        "init_clears_done");
    wr(A_DATA, 32'hFFFFFFFF, 4'hF);
    wait_idle(n);
    check("busy_cycles_ones", 32'(n), 32'd32);
    rd(A_CRC, 32'h0, "crc_all_ones");

    // overrun: second DATA write 10 cycles later, CRC write mid-word ignored
    wr(A_CRC, 32'h0, 4'hF);
    wr(A_DATA, D1, 4'hF);
    cycles(9);
    wr(A_DATA, 32'h5, 4'hF);
    wr(A_CRC, 32'hFFFFFFFF, 4'hF);
    rd(A_STAT, 32'h5, "status_overrun_busy");
    wait_idle(n);
    rd(A_CRC,  E1,    "crc_after_overrun");
    rd(A_STAT, 32'h6, "status_overrun_done");
    wr(A_STAT, 32'h4, 4'hF);
    rd(A_STAT, 32'h2, "overrun_cleared");

    // INIT at cycle 16 of a word
    wr(A_CRC, 32'h0, 4'hF);
    wr(A_DATA, D1, 4'hF);
    cycles(15);
    wr(A_CTRL, 32'h1, 4'hF);
    check("init_abort_busy", {31'b0, BUSY}, 32'h0);
    rd(A_CRC,  32'hFFFFFFFF, "init_abort_crc");
    rd(A_STAT, 32'h0,        "init_abort_status");

    // reset pulse mid-word with OVERRUN set
    wr(A_DATA, D1, 4'hF);
    cycles(3);
    wr(A_DATA, 32'h7, 4'hF);
    rd(A_STAT, 32'h5, "pre_reset_status");
    cycles(2);
    RESET_N = 1'b0;
    #3;
    check("reset_mid_readdata", AVL_READDATA, 32'h0);
    check("reset_mid_busy", {31'b0, BUSY}, 32'h0);
    #5;
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    rd(A_STAT, 32'h0,        "post_reset_status");
    rd(A_CRC,  32'hFFFFFFFF, "post_reset_crc");

    cycles(4);
    if (exp_q.size() != 0) begin
      n_total++;
      n_bad++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/avalon_crc32_slave.md
# avalon_crc32_slave

Avalon-MM responder peripheral for the Nios II system. It accepts 32-bit data words written by the processor and folds them into a running CRC-32 with a bit-serial engine, one bit per clock. Software can poll the result and status registers. It is instantiated inside the Platform Designer system on the 50 MHz system clock and reset.

## Interface
- CRC_POLY, 32'h04C11DB7 — generator polynomial, normal (MSB-first) form.
- CRC_INIT, 32'hFFFFFFFF — value loaded into CRC by the INIT command and at reset.
- CLK  in  1  system clock, 50 MHz; all logic on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- AVL_CS  in  1  chip select; READ/WRITE are ignored when low.
- AVL_READ  in  1  read strobe.
- AVL_WRITE  in  1  write strobe.
- AVL_ADDR  in  2  word address: 0 CTRL, 1 DATA, 2 CRC, 3 STATUS.
- AVL_BYTE_EN  in  4  byte enables; honoured only for CRC writes.
- AVL_WRITEDATA  in  32  write data.
- AVL_READDATA  out  32  registered read data.
- BUSY  out  1  engine active; exported conduit, e.g. to an LED.

## Operation
- Reset: CRC=CRC_INIT, state IDLE, BUSY=0, DONE=0, OVERRUN=0, AVL_READDATA=0.
- CTRL write, bit0=1 (INIT):
  - CRC=CRC_INIT, DONE=0.
  - Aborts any word in progress; state IDLE, BUSY=0.
  - Other bits ignored.
  - CTRL reads return 0.
- DATA write in IDLE:
  - Shift register takes the full AVL_WRITEDATA; byte enables ignored.
  - Bit counter cleared; state SHIFT, BUSY=1, DONE=0.
- DATA write in SHIFT: word dropped, OVERRUN=1 (sticky).
- CRC write:
  - In IDLE, loads the seed byte-wise per AVL_BYTE_EN.
  - In SHIFT, ignored.
  - CRC reads return the current register; mid-word values are partial.
- STATUS read: {29'b0, OVERRUN, DONE, BUSY}.
- STATUS write: bit2=1 clears OVERRUN (write-1-to-clear); other bits ignored.
- SHIFT, one bit per cycle, MSB-first:
  - fb = CRC[31]^SR[31].
  - CRC = {CRC[30:0],0} ^ (fb ? CRC_POLY : 0).
  - SR <<= 1.
- After the 32nd bit (counter==31): state IDLE, BUSY=0, DONE=1.
- States: IDLE -(DATA write)-> SHIFT -(counter==31 or INIT)-> IDLE.
- Simultaneous events: a write in the same cycle as the final shift bit is treated as occurring in SHIFT; a DATA write there is dropped with OVERRUN=1.
- No final XOR and no output reflection; software applies these.
- Unselected or idle bus cycles leave AVL_READDATA unchanged.

## Timing
- Write accepted in the cycle AVL_CS&AVL_WRITE is high. Zero wait states; no waitrequest.
- Read latency is exactly 1 cycle: AVL_READDATA is valid the cycle after AVL_CS&AVL_READ. The component hw.tcl declares readLatency=1.
- DATA write sampled at edge N:
  - BUSY=1 from edge N through N+31.
  - BUSY=0 and DONE=1 from edge N+32.
  - A read issued at N+32 returns the final CRC.
- Throughput: one word per 32 cycles. Software must poll BUSY or DONE between words.
- Reset asserted mid-word: immediate return to reset values; no partial state survives.

## Configuration
- CRC_REFLECT_EN defined:
  - Engine is LSB-first.
  - fb = CRC[0]^SR[0].
  - CRC = (CRC>>1) ^ (fb ? bitrev(CRC_POLY) : 0).
  - SR >>= 1.
  - With the default polynomial the effective constant is 32'hEDB88320.
- CRC_REFLECT_EN undefined: MSB-first as in Operation.
- Register map, timing and reset values are identical in both builds.

## Structure
- Package crc32_pkg holds:
  - register offset constants (CTRL/DATA/CRC/STATUS);
  - STATUS bit positions;
  - state enum {IDLE, SHIFT};
  - bitrev32 function.
- Sub-module crc32_bit_engine holds:
  - shift register, CRC register, 5-bit counter, state.
  - Inputs: load, data, seed_load, seed_be, seed, init, abort.
  - Outputs: crc, busy, done_pulse.
- Top level holds address decode, STATUS flags and the registered read mux.

## Test plan
- MSB build, CRC write 0 (BYTE_EN=F), DATA write 32'h00000001 -> BUSY for 32 cycles, STATUS=3'b010, CRC reads 32'h04C11DB7.
- MSB build, INIT, DATA write 32'hFFFFFFFF -> CRC reads 32'h00000000 after 32 cycles.
- CRC_REFLECT_EN build, CRC write 0, DATA write 32'h80000000 -> CRC reads 32'hEDB88320.
- DATA write 32'h1, second DATA write 10 cycles later:
  - STATUS reads 3'b101 (OVERRUN, BUSY); final CRC 32'h04C11DB7.
  - STATUS write 32'h4 -> OVERRUN cleared.
- CRC write 32'h12345678 with BYTE_EN=4'b0011 after reset -> CRC reads 32'hFFFF5678.
- INIT at cycle 16 of a word -> BUSY=0 next cycle, CRC=32'hFFFFFFFF, DONE=0. RESET_N pulse mid-word -> all reset values.
